// File: rtl/pu_pkg.sv
// Shared widths, lane/bundle types and FSM state encoding for the PU operand loader.
package pu_pkg;

    localparam int unsigned XLEN  = 5;
    localparam int unsigned LANES = 4;
    localparam int unsigned IDX_W = $clog2(LANES);

    typedef logic [XLEN-1:0]  word_t;
    typedef word_t [LANES-1:0] lanes_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/pu_lane_bank.sv
// Four-lane operand register bank: clear, whole-bank load, indexed write with
// optional zero-fill of the lanes above the written index.
module pu_lane_bank
    import pu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr_i,
    input  logic   load_i,
    input  lanes_t load_lanes_i,
    input  logic   we_i,
    input  idx_t   widx_i,
    input  word_t  wdata_i,
    input  logic   zfill_i,
    output lanes_t lanes_o
);

    lanes_t lanes_q, lanes_d;

    // Priority: clear, then load, then the indexed write lands on top of a load.
    always_comb begin
        lanes_d = lanes_q;
        if (clr_i) begin
            lanes_d = '0;
        end else begin
            if (load_i) begin
                lanes_d = load_lanes_i;
            end
            if (we_i) begin
                lanes_d[widx_i] = wdata_i;
                if (zfill_i) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (IDX_W'(i) > widx_i) begin
                            lanes_d[i] = '0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign lanes_o = lanes_q;

endmodule

// File: rtl/pu_operand_loader.sv
// Serial-to-parallel operand loader: packs four XLEN words into one PU bundle.
// Define PU_LOADER_SKID_EN to add a shadow bank that keeps filling while a bundle is held.
module pu_operand_loader
    import pu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [XLEN-1:0] out_num1,
    output logic [XLEN-1:0] out_num2,
    output logic [XLEN-1:0] out_num3,
    output logic [XLEN-1:0] out_num4,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_partial
);

    state_e state_q, state_d;
    idx_t   idx_q, idx_d;
    logic   partial_q, partial_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;

    logic   accept, xfer, close, pclose;
    logic   ob_load, ob_we, ob_zf;
    lanes_t ob_lanes, ob_load_lanes;

`ifdef PU_LOADER_SKID_EN
    logic   sh_full_q, sh_full_d, sh_partial_q, sh_partial_d;
    logic   sb_we, sb_zf, sb_clr;
    lanes_t sb_lanes;
`endif

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;
    assign close  = accept && ((idx_q == LAST_IDX) || in_last);
    assign pclose = accept && in_last && (idx_q != LAST_IDX);

    // Next-state: FILL writes the output bank; HOLD presents it until transfer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        partial_d = partial_q;
        ob_load   = 1'b0;
        ob_we     = 1'b0;
        ob_zf     = 1'b0;
`ifdef PU_LOADER_SKID_EN
        sh_full_d    = sh_full_q;
        sh_partial_d = sh_partial_q;
        sb_we        = 1'b0;
        sb_zf        = 1'b0;
        sb_clr       = 1'b0;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    ob_we = 1'b1;
                    ob_zf = pclose;
                    if (close) begin
                        state_d   = HOLD;
                        idx_d     = '0;
                        partial_d = pclose;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end
            end
            HOLD: begin
`ifdef PU_LOADER_SKID_EN
                // Transfer always promotes the shadow bank; a same-cycle word lands on the promoted copy.
                if (xfer) begin
                    ob_load      = 1'b1;
                    sb_clr       = 1'b1;
                    sh_full_d    = 1'b0;
                    sh_partial_d = 1'b0;
                    if (sh_full_q) begin
                        partial_d = sh_partial_q;
                    end else if (accept) begin
                        ob_we = 1'b1;
                        ob_zf = pclose;
                        if (close) begin
                            partial_d = pclose;
                            idx_d     = '0;
                        end else begin
                            state_d = FILL;
                            idx_d   = idx_q + idx_t'(1);
                        end
                    end else begin
                        state_d = FILL;
                    end
                end else if (accept) begin
                    sb_we = 1'b1;
                    sb_zf = pclose;
                    if (close) begin
                        sh_full_d    = 1'b1;
                        sh_partial_d = pclose;
                        idx_d        = '0;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end
`else
                if (xfer) begin
                    state_d = FILL;
                end
`endif
            end
            default: state_d = FILL;
        endcase

`ifdef PU_LOADER_SKID_EN
        in_ready_d = !sh_full_d;
`else
        in_ready_d = (state_d == FILL);
`endif
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            partial_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            partial_q   <= partial_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PU_LOADER_SKID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_full_q    <= 1'b0;
            sh_partial_q <= 1'b0;
        end else begin
            sh_full_q    <= sh_full_d;
            sh_partial_q <= sh_partial_d;
        end
    end

    pu_lane_bank u_shadow_bank (
        .clk          (clk),
        .rst_n        (rst),
        .clr_i        (sb_clr),
        .load_i       (1'b0),
        .load_lanes_i ('0),
        .we_i         (sb_we),
        .widx_i       (idx_q),
        .wdata_i      (in_data),
        .zfill_i      (sb_zf),
        .lanes_o      (sb_lanes)
    );

    assign ob_load_lanes = sb_lanes;
`else
    assign ob_load_lanes = '0;
`endif

    pu_lane_bank u_out_bank (
        .clk          (clk),
        .rst_n        (rst),
        .clr_i        (1'b0),
        .load_i       (ob_load),
        .load_lanes_i (ob_load_lanes),
        .we_i         (ob_we),
        .widx_i       (idx_q),
        .wdata_i      (in_data),
        .zfill_i      (ob_zf),
        .lanes_o      (ob_lanes)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_partial = partial_q;
    assign out_num1    = ob_lanes[0];
    assign out_num2    = ob_lanes[1];
    assign out_num3    = ob_lanes[2];
    assign out_num4    = ob_lanes[3];

endmodule
